// File: rtl/bcd_counter_chain_if.sv
// Control/data bundle for the BCD counter chain.
// The master drives the count controls; the slave (counter) returns count and flags.
interface bcd_counter_chain_if #(
  parameter int DIGITS = 4
);
  logic                  ena;
  logic                  up_dn;
  logic                  clr;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   Qdata;
  logic [DIGITS-1:0]     match;
  logic                  tc;
  logic                  load_err;

  modport master (
    output ena, up_dn, clr, load, load_val,
    input  Qdata, match, tc, load_err
  );

  modport slave (
    input  ena, up_dn, clr, load, load_val,
    output Qdata, match, tc, load_err
  );
endinterface

// File: rtl/bcd_counter_chain.sv
// Multi-digit BCD up/down counter with programmable terminal value, load/clear,
// per-digit match flags and registered wrap / load-reject pulses.
module bcd_counter_chain #(
  parameter int                  DIGITS     = 4,
  parameter logic [4*DIGITS-1:0] LIMIT      = 16'h9675,
  parameter bit                  MATCH_HOLD = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  bcd_counter_chain_if.slave bus
);
  localparam int W = 4 * DIGITS;

  logic [W-1:0]      count_q, count_d;
  logic [W-1:0]      inc_val, dec_val;
  logic              tc_q, tc_d;
  logic              err_q, err_d;
  logic [DIGITS-1:0] match_c;
  logic              illegal;
  logic              ld_digits_ok;
  logic              load_ok;
  logic              at_limit;
  logic              at_zero;

  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("bcd_counter_chain: DIGITS must be 1..8");
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_lim_chk
    if (LIMIT[4*g +: 4] > 4'd9) begin : g_bad_nibble
      $error("bcd_counter_chain: LIMIT nibble is not a BCD digit");
    end
  end

  // Ripple carry/borrow across digits: a digit steps only when all lower digits wrap.
  always_comb begin
    logic carry;
    logic borrow;
    carry        = 1'b1;
    borrow       = 1'b1;
    illegal      = 1'b0;
    ld_digits_ok = 1'b1;
    match_c      = '0;
    inc_val      = count_q;
    dec_val      = count_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (count_q[4*i +: 4] > 4'd9)      illegal      = 1'b1;
      if (bus.load_val[4*i +: 4] > 4'd9) ld_digits_ok = 1'b0;
      match_c[i] = (count_q[4*i +: 4] == LIMIT[4*i +: 4]);
      if (carry)
        inc_val[4*i +: 4] = (count_q[4*i +: 4] == 4'd9) ? 4'd0 : count_q[4*i +: 4] + 4'd1;
      if (borrow)
        dec_val[4*i +: 4] = (count_q[4*i +: 4] == 4'd0) ? 4'd9 : count_q[4*i +: 4] - 4'd1;
      carry  = carry  & (count_q[4*i +: 4] == 4'd9);
      borrow = borrow & (count_q[4*i +: 4] == 4'd0);
    end
  end

  assign at_limit = (count_q == LIMIT);
  assign at_zero  = (count_q == '0);
  // With every nibble valid, packed binary order equals BCD magnitude order.
  assign load_ok  = ld_digits_ok && (bus.load_val <= LIMIT);

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    err_d   = 1'b0;
    if (bus.clr) begin
      count_d = '0;
    end else if (bus.load) begin
      if (load_ok) count_d = bus.load_val;
      else         err_d   = 1'b1;
    end else if (bus.ena) begin
      if (illegal) begin
        count_d = '0;
      end else if (bus.up_dn) begin
        if (at_limit) begin
          count_d = '0;
          tc_d    = 1'b1;
        end else begin
          count_d = inc_val;
        end
      end else begin
        if (at_zero) begin
          count_d = LIMIT;
          tc_d    = 1'b1;
        end else begin
          count_d = dec_val;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      err_q   <= err_d;
    end
  end

  if (MATCH_HOLD) begin : g_match_reg
    logic [DIGITS-1:0] match_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) match_q <= '0;
      else     match_q <= match_c;
    end
    assign bus.match = match_q;
  end else begin : g_match_comb
    assign bus.match = match_c;
  end

  assign bus.Qdata    = count_q;
  assign bus.tc       = tc_q;
  assign bus.load_err = err_q;
endmodule

// File: tb/tb_bcd_counter_chain.sv
// Bench for bcd_counter_chain: directed vector table, corner sequences and random
// stimulus against a decimal-arithmetic model, on a 4-digit and a 2-digit registered-match build.
module tb_bcd_counter_chain;
  localparam int LIM_A = 9675;
  localparam int LIM_B = 59;

  typedef struct {
    bit          clr;
    bit          load;
    bit          ena;
    bit          up;
    logic [15:0] lv;
  } in_t;

  typedef struct {
    in_t         x;
    logic [15:0] q;
    bit          tc;
    bit          err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bcd_counter_chain_if #(.DIGITS(4)) ifa ();
  bcd_counter_chain_if #(.DIGITS(2)) ifb ();

  bcd_counter_chain #(.DIGITS(4), .LIMIT(16'h9675), .MATCH_HOLD(1'b0)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa));
  bcd_counter_chain #(.DIGITS(2), .LIMIT(8'h59), .MATCH_HOLD(1'b1)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb));

  int checks = 0;
  int errors = 0;
  int ma = 0, mb = 0;
  bit ta, ea, tb, eb;
  in_t idle = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0};

  function automatic int bcd2int(logic [15:0] b, int nd);
    int r = 0, p = 1;
    for (int i = 0; i < nd; i++) begin
      r += int'(b[4*i +: 4]) * p;
      p *= 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] int2bcd(int v, int nd);
    logic [31:0] r = '0;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic bit bcd_ok(logic [15:0] b, int nd);
    for (int i = 0; i < nd; i++)
      if (b[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] mcmp(int v, int lim, int nd);
    logic [31:0] r = '0;
    for (int i = 0; i < nd; i++) begin
      r[i] = ((v % 10) == (lim % 10));
      v = v / 10;
      lim = lim / 10;
    end
    return r;
  endfunction

  function automatic void mstep(input int lim, input int nd, inout int v,
                                output bit tc, output bit err, input in_t x);
    tc = 1'b0;
    err = 1'b0;
    if (x.clr) v = 0;
    else if (x.load) begin
      if (bcd_ok(x.lv, nd) && bcd2int(x.lv, nd) <= lim) v = bcd2int(x.lv, nd);
      else err = 1'b1;
    end else if (x.ena) begin
      if (x.up) begin
        if (v == lim) begin v = 0; tc = 1'b1; end
        else v = v + 1;
      end else begin
        if (v == 0) begin v = lim; tc = 1'b1; end
        else v = v - 1;
      end
    end
  endfunction

  function automatic in_t mkin(bit c, bit l, bit e, bit u, logic [15:0] lv);
    in_t r;
    r.clr = c; r.load = l; r.ena = e; r.up = u; r.lv = lv;
    return r;
  endfunction

  function automatic vec_t mkv(bit c, bit l, bit e, bit u, logic [15:0] lv,
                               logic [15:0] q, bit t, bit er);
    vec_t r;
    r.x = mkin(c, l, e, u, lv); r.q = q; r.tc = t; r.err = er;
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(in_t a, in_t b);
    ifa.clr = a.clr; ifa.load = a.load; ifa.ena = a.ena; ifa.up_dn = a.up;
    ifa.load_val = a.lv;
    ifb.clr = b.clr; ifb.load = b.load; ifb.ena = b.ena; ifb.up_dn = b.up;
    ifb.load_val = b.lv[7:0];
  endtask

  task automatic step(in_t a, in_t b);
    int old_b;
    drive(a, b);
    @(posedge clk);
    #1;
    old_b = mb;
    mstep(LIM_A, 4, ma, ta, ea, a);
    mstep(LIM_B, 2, mb, tb, eb, b);
    chk("a_q", 32'(ifa.Qdata), int2bcd(ma, 4));
    chk("a_tc", 32'(ifa.tc), 32'(ta));
    chk("a_err", 32'(ifa.load_err), 32'(ea));
    chk("a_match", 32'(ifa.match), mcmp(ma, LIM_A, 4));
    chk("b_q", 32'(ifb.Qdata), int2bcd(mb, 2));
    chk("b_tc", 32'(ifb.tc), 32'(tb));
    chk("b_err", 32'(ifb.load_err), 32'(eb));
    chk("b_match_lag", 32'(ifb.match), mcmp(old_b, LIM_B, 2));
  endtask

  task automatic reset_all();
    drive(idle, idle);
    rst = 1'b1;
    #2;
    chk("rst_a_q", 32'(ifa.Qdata), 32'h0);
    chk("rst_a_tc", 32'(ifa.tc), 32'h0);
    chk("rst_a_err", 32'(ifa.load_err), 32'h0);
    chk("rst_b_match", 32'(ifb.match), 32'h0);
    ma = 0;
    mb = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vec_t vt[$];
    in_t  ra, rb;
    int   tcs, mall;

    drive(idle, idle);
    reset_all();

    // Directed vectors on the 4-digit counter
    vt.push_back(mkv(0, 0, 1, 0, 16'h0000, 16'h9675, 1, 0));
    vt.push_back(mkv(0, 0, 1, 0, 16'h0000, 16'h9674, 0, 0));
    vt.push_back(mkv(0, 0, 1, 0, 16'h0000, 16'h9673, 0, 0));
    vt.push_back(mkv(0, 0, 1, 0, 16'h0000, 16'h9672, 0, 0));
    vt.push_back(mkv(0, 0, 1, 0, 16'h0000, 16'h9671, 0, 0));
    vt.push_back(mkv(0, 0, 1, 0, 16'h0000, 16'h9670, 0, 0));
    vt.push_back(mkv(0, 0, 1, 0, 16'h0000, 16'h9669, 0, 0));
    vt.push_back(mkv(0, 1, 0, 0, 16'h9600, 16'h9600, 0, 0));
    vt.push_back(mkv(0, 0, 1, 0, 16'h0000, 16'h9599, 0, 0));
    vt.push_back(mkv(0, 1, 0, 0, 16'h0999, 16'h0999, 0, 0));
    vt.push_back(mkv(0, 0, 1, 1, 16'h0000, 16'h1000, 0, 0));
    vt.push_back(mkv(0, 1, 0, 0, 16'h9676, 16'h1000, 0, 1));
    vt.push_back(mkv(0, 1, 0, 0, 16'h12A4, 16'h1000, 0, 1));
    vt.push_back(mkv(0, 1, 0, 0, 16'h5432, 16'h5432, 0, 0));
    vt.push_back(mkv(1, 1, 1, 1, 16'h9999, 16'h0000, 0, 0));
    vt.push_back(mkv(0, 1, 1, 1, 16'h0100, 16'h0100, 0, 0));
    vt.push_back(mkv(0, 0, 1, 1, 16'h0000, 16'h0101, 0, 0));
    vt.push_back(mkv(0, 0, 1, 0, 16'h0000, 16'h0100, 0, 0));
    vt.push_back(mkv(0, 0, 1, 0, 16'h0000, 16'h0099, 0, 0));
    vt.push_back(mkv(0, 1, 0, 0, 16'h9675, 16'h9675, 0, 0));
    vt.push_back(mkv(0, 0, 1, 1, 16'h0000, 16'h0000, 1, 0));
    vt.push_back(mkv(0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0));
    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].x, idle);
      chk($sformatf("vec%0d_q", i), 32'(ifa.Qdata), 32'(vt[i].q));
      chk($sformatf("vec%0d_tc", i), 32'(ifa.tc), 32'(vt[i].tc));
      chk($sformatf("vec%0d_err", i), 32'(ifa.load_err), 32'(vt[i].err));
    end

    // Asynchronous reset between edges while a load_err pulse is showing
    step(mkin(0, 1, 0, 0, 16'h4321), idle);
    step(mkin(0, 1, 0, 0, 16'h9999), idle);
    chk("pre_rst_err", 32'(ifa.load_err), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_q", 32'(ifa.Qdata), 32'h0);
    chk("async_rst_err", 32'(ifa.load_err), 32'h0);
    chk("async_rst_tc", 32'(ifa.tc), 32'h0);
    ma = 0;
    mb = 0;
    @(negedge clk);
    rst = 1'b0;
    step(mkin(0, 0, 1, 1, 16'h0), idle);
    chk("post_rst_first", 32'(ifa.Qdata), 32'h0001);

    // Full up-count cycle of the 4-digit chain
    reset_all();
    tcs = 0;
    mall = 0;
    for (int i = 0; i < LIM_A + 1; i++) begin
      step(mkin(0, 0, 1, 1, 16'h0), idle);
      if (ifa.tc) tcs++;
      if (&ifa.match) mall++;
    end
    chk("full_wrap_q", 32'(ifa.Qdata), 32'h0);
    chk("full_tc_count", 32'(tcs), 32'd1);
    chk("full_match_count", 32'(mall), 32'd1);

    // 2-digit registered-match build: 120 up steps wrap twice
    reset_all();
    tcs = 0;
    for (int i = 0; i < 120; i++) begin
      step(idle, mkin(0, 0, 1, 1, 16'h0));
      if (ifb.tc) tcs++;
    end
    chk("b_tc_count", 32'(tcs), 32'd2);
    chk("b_final_q", 32'(ifb.Qdata), 32'h00);

    // Random traffic on both builds
    for (int i = 0; i < 3000; i++) begin
      ra.clr  = ($urandom_range(0, 31) == 0);
      ra.load = ($urandom_range(0, 15) == 0);
      ra.ena  = ($urandom_range(0, 3) != 0);
      ra.up   = 1'($urandom_range(0, 1));
      ra.lv   = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'(int2bcd($urandom_range(0, 9999), 4));
      rb.clr  = ($urandom_range(0, 31) == 0);
      rb.load = ($urandom_range(0, 15) == 0);
      rb.ena  = ($urandom_range(0, 3) != 0);
      rb.up   = 1'($urandom_range(0, 1));
      rb.lv   = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 255)) : 16'(int2bcd($urandom_range(0, 99), 2));
      step(ra, rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bcd_counter_chain.md
Name: bcd_counter_chain

Overview:
Parametrised multi-digit BCD counter with a programmable terminal value. It replaces fixed four-digit counter chains: up/down counting, synchronous load/clear, per-digit match flags and a wrap pulse. It sits between the free-running enable source and the display/LED logic. The registered wrap is one clean cycle, with no extra cycle spent at zero.

Parameters:
DIGITS, 4, number of BCD digits in the chain (1..8)
LIMIT, 16'h9675, terminal count in packed BCD, width 4*DIGITS; every nibble must be 0..9
MATCH_HOLD, 0, 1 = match[] are registered (one cycle late), 0 = combinational from Qdata

Ports:
clk       input   1           system clock, all state on rising edge
rst       input   1           asynchronous reset, active-high
ena       input   1           count enable, one step per cycle while high
up_dn     input   1           1 = count up, 0 = count down
clr       input   1           synchronous clear to zero
load      input   1           synchronous load of load_val
load_val  input   4*DIGITS    packed BCD value to load
Qdata     output  4*DIGITS    packed BCD count, digit 0 in [3:0]
match     output  DIGITS      match[i] = digit i equals LIMIT digit i
tc        output  1           registered one-cycle pulse on wrap (either direction)
load_err  output  1           registered one-cycle pulse when a load is rejected

Behaviour:
- Reset (async, rst=1): Qdata=0, tc=0, load_err=0, registered match=0. Outputs settle without a clock edge. Counting resumes on the first rising edge after rst falls.
- Priority per edge: clr > load > ena. When none is asserted, Qdata holds. up_dn is sampled only when ena is acting.
- clr: next Qdata=0; tc=0; load_err=0.
- load: accepted when every nibble of load_val is <=9 and load_val <= LIMIT (BCD magnitude compare).
  - Accepted: next Qdata=load_val.
  - Rejected: Qdata holds and load_err=1 for one cycle.
  - A load cycle never counts, even if ena=1.
- Up count (ena=1, up_dn=1):
  - Digit i increments when all lower digits are 9, or when i=0.
  - A digit at 9 rolls to 0 and carries into the next digit.
  - When Qdata==LIMIT: next Qdata=0 and tc=1 in the same edge. There is no cycle spent at LIMIT+1.
- Down count (ena=1, up_dn=0):
  - Digit i decrements when all lower digits are 0, or when i=0.
  - 0 borrows to 9.
  - When Qdata==0: next Qdata=LIMIT and tc=1.
- tc and load_err are registered and high for exactly one cycle per event. They are 0 on the cycle after, unless the event repeats (e.g. LIMIT=0 with ena held gives tc every cycle).
- match:
  - MATCH_HOLD=0: combinational compare of Qdata against LIMIT per digit.
  - MATCH_HOLD=1: the same compare registered; reset to 0.
  - &match is 1 exactly when Qdata==LIMIT.
- Direction change: up_dn may toggle on any cycle. The step always uses the current Qdata, with no pipeline hazard.
- Illegal state: if Qdata ever holds a nibble >9 (e.g. an X recovery), the next count step forces Qdata to 0, with no tc.
- Elaboration: a LIMIT nibble >9, or DIGITS outside 1..8, triggers a $error.
- Latency: every change is one clk edge from input to Qdata. There is no combinational path from inputs to Qdata.

Test Plan:
- DIGITS=4, LIMIT=9675, up, ena=1 for 9676 cycles from reset -> Qdata steps 0000..9675, then 0000; tc high exactly once, on the wrap edge; match=4'b1111 only at 9675.
- Down from 0000, one ena cycle -> Qdata=9675, tc=1 for one cycle. Continue: 9675->9674, ... 9670->9669 (check borrow); 9600->9599.
- load_val=0x0999, load=1 -> Qdata=0999. Then up one step -> 1000 (triple carry). Then load_val=0x9676 -> load_err=1 and Qdata stays 1000. Then load_val=0x12A4 -> load_err=1.
- clr, load and ena asserted on the same edge with Qdata=5432 -> Qdata=0000, load_err=0. Next, load+ena with load_val=0x0100 -> Qdata=0100, no count.
- Assert rst asynchronously mid-count at 4321 (between edges) -> Qdata=0000 immediately; tc/load_err=0. After rst deassertion, the first ena edge -> 0001.
- DIGITS=2, LIMIT=8'h59, MATCH_HOLD=1, up 120 cycles -> wraps 59->00 twice, tc pulses 2; match lags Qdata by one cycle.
